seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU; successor to the 8-bit combinational ALU datapath.
//   Adds a START/BUSY/DONE handshake, variable shift amounts (one bit per cycle),
//   an iterative shift-add unsigned multiply (MUL), and registered result and flags.
//   Sits between the register file and the writeback mux of the lab CPU datapath.
// PARAMETERS
//   WIDTH  8              operand/result width in bits; must be >= 4
//   SHW    $clog2(WIDTH)  shift-amount field width, taken from B[SHW-1:0]
// PORTS
//   CLK    in   1        single clock; all state updates on the rising edge
//   RESET  in   1        synchronous, active-high reset
//   START  in   1        request; sampled only when BUSY=0
//   A      in   WIDTH    operand A; captured when START is accepted
//   B      in   WIDTH    operand B, or shift amount in B[SHW-1:0]; captured when START is accepted
//   OP     in   3        000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 MUL
//   BUSY   out  1        operation in progress; START is ignored while high
//   DONE   out  1        one-cycle pulse; Y, YH and the flags update in the same cycle
//   Y      out  WIDTH    result; low half of the product for MUL
//   YH     out  WIDTH    high half of the product for MUL; 0 for every other op
//   C, V, N, Z  out 1    registered flags for the last completed op
// BEHAVIOUR
//   - Reset: state IDLE; BUSY=0, DONE=0, Y=0, YH=0, C=V=N=Z=0. Reset mid-operation
//     aborts the operation with no DONE pulse.
//   - FSM has two states, IDLE and EXEC. START is accepted at edge k only when the FSM is in IDLE.
//     On acceptance A, B and OP are latched; later input changes have no effect.
//   - ADD, SUB, AND, OR, and any shift with amount s=0:
//       - stay in IDLE; latency 1.
//       - after edge k: Y and the flags are loaded and DONE=1.
//   - Shifts with s>=1, and MUL: go to EXEC with BUSY=1.
//       - a counter is loaded with s for a shift, or WIDTH for MUL.
//       - one step per edge; the counter decrements each step.
//       - on the last step the FSM returns to IDLE, writes the result and pulses DONE.
//       - latency is s cycles for a shift and WIDTH cycles for MUL.
//   - BUSY=0 in the DONE cycle, so a START in that cycle is accepted: back-to-back issue is legal.
//   - ADD/SUB: Y = A + (SUB ? ~B : B) + SUB, truncated to WIDTH.
//       - C = carry out of the MSB; for SUB, C=1 means no borrow.
//       - V = signed overflow.
//   - SRA/SRL/SLL: each step shifts by 1 bit.
//       - C = last bit shifted out; C=0 when s=0.
//       - V=0.
//       - SRA replicates the MSB; SRL and SLL fill with 0.
//   - AND/OR: C=0, V=0.
//   - MUL: unsigned A*B, 2*WIDTH-bit product, computed by shift-add (one multiplier bit per step).
//       - {YH,Y} = product.
//       - C = V = (YH != 0).
//   - N = MSB of Y for every op.
//   - Z = (Y == 0), except for MUL, where Z = ({YH,Y} == 0).
//   - Between DONE pulses, Y, YH and the flags hold their values.
// STRUCTURE
//   - Package alu_pkg holds the OP_* opcode localparams (3-bit) and the FSM state encoding
//     ST_IDLE/ST_EXEC.
//   - One sub-module, alu_addsub: combinational WIDTH-bit add/sub producing Y, C and V.
//     It is also reused as the MUL accumulator adder.
//   - The top level holds the FSM, the step counter, the operand/shift registers and the
//     output registers.
// TESTING (WIDTH=8)
//   - ADD A=7F B=01 -> 1 cycle later: DONE=1, Y=80, C=0, V=1, N=1, Z=0, YH=00.
//   - SUB A=05 B=05 -> Y=00, Z=1, C=1, V=0; then SUB A=00 B=01 -> Y=FF, C=0, N=1.
//   - SRA A=81 B=03 -> BUSY=1 for cycles 1-2, DONE after 3 cycles: Y=F0, C=0, N=1.
//     Then SLL A=01 B=07 -> Y=80, latency 7.
//   - MUL A=10 B=10 -> DONE after 8 cycles: Y=00, YH=01, C=V=1, Z=0.
//     Then MUL A=FF B=FF -> YH=FE, Y=01.
//   - During a MUL, pulse START with OP=ADD -> ignored. RESET at cycle 4 -> no DONE, all outputs 0.
//     A new START is then accepted normally.
//   - Back-to-back: ADD issued in the DONE cycle of SRL A=80 B=01 (Y=40, C=0) -> both complete
//     in order with correct results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and opcode type for the sequential ALU.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_SRL = 3'b011;
  localparam op_t OP_SLL = 3'b100;
  localparam op_t OP_AND = 3'b101;
  localparam op_t OP_OR  = 3'b110;
  localparam op_t OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath and the sequential ALU.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  op_t              OP;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] YH;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;

  modport master (
    output START, A, B, OP,
    input  BUSY, DONE, Y, YH, C, V, N, Z
  );

  modport slave (
    input  START, A, B, OP,
    output BUSY, DONE, Y, YH, C, V, N, Z
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_c_o,
  output logic             cout_c_o,
  output logic             ovf_c_o
);

  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH-1:0] b_eff;

  assign b_eff              = sub_i ? ~b_i : b_i;
  assign {cout_c_o, sum_c_o} = {1'b0, a_i} + {1'b0, b_eff} + XW'(sub_i);
  // Overflow: operands of equal sign produce a result of the other sign.
  assign ovf_c_o            = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                              (sum_c_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts and shift-add multiply
// behind a START/BUSY/DONE handshake with registered result and flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic      CLK,
  input  logic      RESET,
  seq_alu_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q;
  op_t              op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] yh_q;
  logic             c_q;
  logic             v_q;
  logic             n_q;
  logic             z_q;

  logic             idle_c;
  logic             is_shift_c;
  logic             fin_c;
  op_t              op_c;
  logic [SHW-1:0]   s_in_c;
  logic [WIDTH-1:0] sh_c;
  logic [WIDTH-1:0] mq_c;
  logic [WIDTH-1:0] acc_c;
  logic [WIDTH-1:0] add_a_c;
  logic [WIDTH-1:0] add_b_c;
  logic             add_sub_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sh_nxt_c;
  logic             sh_out_c;
  logic [WIDTH-1:0] addend_c;
  logic [WIDTH-1:0] acc_nxt_c;
  logic [WIDTH-1:0] mq_nxt_c;
  logic [WIDTH-1:0] res_y_c;
  logic [WIDTH-1:0] res_yh_c;
  logic             res_c_c;
  logic             res_v_c;

  // Step operands: live inputs while idle (the first step runs on the accept edge), latched ones in EXEC.
  always_comb begin
    idle_c     = (state_q == ST_IDLE);
    s_in_c     = bus.B[SHW-1:0];
    op_c       = idle_c ? bus.OP : op_q;
    sh_c       = idle_c ? bus.A  : sh_q;
    mq_c       = idle_c ? bus.B  : mq_q;
    acc_c      = idle_c ? '0     : acc_q;
    is_shift_c = (op_c == OP_SRA) || (op_c == OP_SRL) || (op_c == OP_SLL);
    add_a_c    = bus.A;
    add_b_c    = bus.B;
    add_sub_c  = (op_c == OP_SUB);
    if (op_c == OP_MUL) begin
      add_a_c   = acc_c;
      add_b_c   = sh_c;
      add_sub_c = 1'b0;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i      (add_a_c),
    .b_i      (add_b_c),
    .sub_i    (add_sub_c),
    .sum_c_o  (sum_c),
    .cout_c_o (cout_c),
    .ovf_c_o  (ovf_c)
  );

  // One shift step, one multiply step, and the result that would be written this cycle.
  always_comb begin
    case (op_c)
      OP_SRA:  sh_nxt_c = {sh_c[WIDTH-1], sh_c[WIDTH-1:1]};
      OP_SLL:  sh_nxt_c = {sh_c[WIDTH-2:0], 1'b0};
      default: sh_nxt_c = {1'b0, sh_c[WIDTH-1:1]};
    endcase
    sh_out_c  = (op_c == OP_SLL) ? sh_c[WIDTH-1] : sh_c[0];

    addend_c  = mq_c[0] ? sum_c : acc_c;
    acc_nxt_c = {mq_c[0] & cout_c, addend_c[WIDTH-1:1]};
    mq_nxt_c  = {addend_c[0], mq_c[WIDTH-1:1]};

    res_y_c   = sum_c;
    res_yh_c  = '0;
    res_c_c   = cout_c;
    res_v_c   = ovf_c;
    case (op_c)
      OP_AND: begin
        res_y_c = bus.A & bus.B;
        res_c_c = 1'b0;
        res_v_c = 1'b0;
      end
      OP_OR: begin
        res_y_c = bus.A | bus.B;
        res_c_c = 1'b0;
        res_v_c = 1'b0;
      end
      OP_SRA, OP_SRL, OP_SLL: begin
        res_v_c = 1'b0;
        if (idle_c && (s_in_c == '0)) begin
          res_y_c = sh_c;
          res_c_c = 1'b0;
        end else begin
          res_y_c = sh_nxt_c;
          res_c_c = sh_out_c;
        end
      end
      OP_MUL: begin
        res_y_c  = mq_nxt_c;
        res_yh_c = acc_nxt_c;
        res_c_c  = |acc_nxt_c;
        res_v_c  = |acc_nxt_c;
      end
      default: ;
    endcase

    if (idle_c) begin
      fin_c = bus.START && (op_c != OP_MUL) && !(is_shift_c && (s_in_c > SHW'(1)));
    end else begin
      fin_c = (cnt_q == CW'(1));
    end
  end

  // FSM, step registers and registered outputs. The counter holds the steps still to run,
  // so it is loaded one below the step total because the accept edge already ran one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      sh_q    <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      yh_q    <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= fin_c;
      if (fin_c) begin
        y_q  <= res_y_c;
        yh_q <= res_yh_c;
        c_q  <= res_c_c;
        v_q  <= res_v_c;
        n_q  <= res_y_c[WIDTH-1];
        z_q  <= (res_y_c == '0) && (res_yh_c == '0);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            op_q <= bus.OP;
            if (!fin_c) begin
              state_q <= ST_EXEC;
              busy_q  <= 1'b1;
              mq_q    <= mq_nxt_c;
              acc_q   <= acc_nxt_c;
              if (bus.OP == OP_MUL) begin
                sh_q  <= bus.A;
                cnt_q <= CW'(WIDTH - 1);
              end else begin
                sh_q  <= sh_nxt_c;
                cnt_q <= CW'(s_in_c) - CW'(1);
              end
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q - CW'(1);
          mq_q  <= mq_nxt_c;
          acc_q <= acc_nxt_c;
          if (op_q != OP_MUL) begin
            sh_q <= sh_nxt_c;
          end
          if (fin_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.Y    = y_q;
  assign bus.YH   = yh_q;
  assign bus.C    = c_q;
  assign bus.V    = v_q;
  assign bus.N    = n_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=8: table of single operations plus
// hand-written sequences for abort, ignored START and back-to-back issue.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    op_t        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [7:0] yh;
    logic [3:0] cvnz;
    int         lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  vec_t vt[19];

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.C, bus.V, bus.N, bus.Z};
  endfunction

  // Issue one op, scramble the inputs after acceptance, wait for DONE and check it.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = v.op;
    bus.A     = v.a;
    bus.B     = v.b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.A     = ~v.a;
    bus.B     = ~v.b;
    bus.OP    = v.op ^ 3'b101;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (bus.DONE === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk($sformatf("v%0d.busy_c%0d", idx, cyc), 32'(bus.BUSY), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk($sformatf("v%0d.latency", idx), seen ? 32'(cyc) : 32'd0, 32'(v.lat));
    chk($sformatf("v%0d.y", idx), 32'(bus.Y), 32'(v.y));
    chk($sformatf("v%0d.yh", idx), 32'(bus.YH), 32'(v.yh));
    chk($sformatf("v%0d.cvnz", idx), 32'(flags()), 32'(v.cvnz));
    chk($sformatf("v%0d.busy_done", idx), 32'(bus.BUSY), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.done_pulse", idx), 32'(bus.DONE), 32'd0);
    chk($sformatf("v%0d.y_hold", idx), 32'(bus.Y), 32'(v.y));
  endtask

  initial begin
    int   dones;
    vec_t nv;
    n_chk = 0;
    n_err = 0;

    //          op      a      b      y      yh     cvnz     lat
    vt[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1};
    vt[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 8'h00, 4'b1001, 1};
    vt[2]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0010, 1};
    vt[3]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1};
    vt[4]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1100, 1};
    vt[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1};
    vt[6]  = '{OP_OR,  8'h0F, 8'h80, 8'h8F, 8'h00, 4'b0010, 1};
    vt[7]  = '{OP_SRL, 8'h80, 8'h01, 8'h40, 8'h00, 4'b0000, 1};
    vt[8]  = '{OP_SRL, 8'h81, 8'h08, 8'h81, 8'h00, 4'b0010, 1};
    vt[9]  = '{OP_SRA, 8'h80, 8'h00, 8'h80, 8'h00, 4'b0010, 1};
    vt[10] = '{OP_SRA, 8'h81, 8'h03, 8'hF0, 8'h00, 4'b0010, 3};
    vt[11] = '{OP_SLL, 8'h01, 8'h07, 8'h80, 8'h00, 4'b0010, 7};
    vt[12] = '{OP_SRL, 8'h03, 8'h02, 8'h00, 8'h00, 4'b1001, 2};
    vt[13] = '{OP_SLL, 8'hC0, 8'h02, 8'h00, 8'h00, 4'b1001, 2};
    vt[14] = '{OP_SRA, 8'h7F, 8'h07, 8'h00, 8'h00, 4'b1001, 7};
    vt[15] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1100, 8};
    vt[16] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1100, 8};
    vt[17] = '{OP_MUL, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0001, 8};
    vt[18] = '{OP_MUL, 8'h0F, 8'h03, 8'h2D, 8'h00, 4'b0000, 8};

    rst       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.OP    = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.BUSY), 32'd0);
    chk("reset.done", 32'(bus.DONE), 32'd0);
    chk("reset.y", 32'(bus.Y), 32'd0);
    chk("reset.yh", 32'(bus.YH), 32'd0);
    chk("reset.cvnz", 32'(flags()), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle.done", 32'(bus.DONE), 32'd0);

    for (int i = 0; i < 19; i++) begin
      run_vec(i, vt[i]);
    end

    // MUL with a START pulse during BUSY, then reset in cycle 4 aborts it.
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = OP_MUL;
    bus.A     = 8'h10;
    bus.B     = 8'h10;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("abort.busy_c1", 32'(bus.BUSY), 32'd1);
    @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.OP    = OP_ADD;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("ignored.done", 32'(bus.DONE), 32'd0);
    chk("ignored.busy", 32'(bus.BUSY), 32'd1);
    chk("ignored.y_hold", 32'(bus.Y), 32'h2D);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", 32'(bus.BUSY), 32'd0);
    chk("abort.y", 32'(bus.Y), 32'd0);
    chk("abort.yh", 32'(bus.YH), 32'd0);
    chk("abort.cvnz", 32'(flags()), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.DONE === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    chk("abort.no_done", 32'(dones), 32'd0);
    nv = '{OP_ADD, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1};
    run_vec(100, nv);

    // Back-to-back: ADD issued in the DONE cycle of a one-step SRL.
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = OP_SRL;
    bus.A     = 8'h80;
    bus.B     = 8'h01;
    @(posedge clk);
    #1;
    chk("b2b1.done", 32'(bus.DONE), 32'd1);
    chk("b2b1.y", 32'(bus.Y), 32'h40);
    chk("b2b1.c", 32'(bus.C), 32'd0);
    bus.START = 1'b1;
    bus.OP    = OP_ADD;
    bus.A     = 8'h10;
    bus.B     = 8'h20;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("b2b1.add_done", 32'(bus.DONE), 32'd1);
    chk("b2b1.add_y", 32'(bus.Y), 32'h30);
    chk("b2b1.add_cvnz", 32'(flags()), 32'd0);

    // Back-to-back after a multi-cycle SRA.
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = OP_SRA;
    bus.A     = 8'h81;
    bus.B     = 8'h03;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("b2b2.busy_c1", 32'(bus.BUSY), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b2.busy_c2", 32'(bus.BUSY), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b2.done", 32'(bus.DONE), 32'd1);
    chk("b2b2.y", 32'(bus.Y), 32'hF0);
    chk("b2b2.busy_done", 32'(bus.BUSY), 32'd0);
    bus.START = 1'b1;
    bus.OP    = OP_ADD;
    bus.A     = 8'h7F;
    bus.B     = 8'h01;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("b2b2.add_done", 32'(bus.DONE), 32'd1);
    chk("b2b2.add_y", 32'(bus.Y), 32'h80);
    chk("b2b2.add_cvnz", 32'(flags()), 32'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
